sccomp_dump: RTL and testbench

Synthesizable end-of-run capture unit that sits directly downstream of `sccomp` and consumes its register-read debug port. It watches the CPU program counter and triggers on either a halt address or a cycle budget. On trigger it freezes the CPU, walks `reg_sel` through r0..r31 and streams the trigger PC plus all 32 register values over a valid/ready interface toward a UART or trace sink.

---
 rtl/sccomp_dump.sv | 103 ++++++++++
 tb/tb_sccomp_dump.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sccomp_dump.sv
// End-of-run capture unit for sccomp: on a halt PC or cycle-budget trigger it
// freezes the CPU and streams the trigger PC followed by r0..r31 over valid/ready.
module sccomp_dump #(
    parameter logic [31:0] HALT_PC    = 32'h00000048,
    parameter int          MAX_CYCLES = 1000,
    parameter int          CNT_W      = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc,
    output logic        cpu_hold,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [1:0] {RUN, LOAD, EMIT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [4:0]       idx;
    logic             word_is_reg;
    logic             trig_pc, trig_to, trig, hs;

    assign trig_pc = (state == RUN) && (pc == HALT_PC);
    assign trig_to = (state == RUN) && (cyc_cnt == CNT_LAST);
    assign trig    = trig_pc | trig_to;
    assign hs      = (state == EMIT) && out_ready;

    // Combinational so the CPU freezes on the triggering edge itself.
    assign cpu_hold = rstn & ((state != RUN) | trig);
    assign reg_sel  = idx;
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (trig) state_nxt = EMIT;
            EMIT:    if (hs) state_nxt = out_last ? DONE : LOAD;
            LOAD:    state_nxt = EMIT;
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt     <= '0;
            idx         <= '0;
            word_is_reg <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (cyc_cnt != CNT_SAT) cyc_cnt <= cyc_cnt + 1'b1;
                    if (trig) begin
                        out_data    <= pc;
                        out_valid   <= 1'b1;
                        out_last    <= 1'b0;
                        timeout     <= trig_to & ~trig_pc;
                        idx         <= '0;
                        word_is_reg <= 1'b0;
                    end
                end
                EMIT: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        if (out_last) out_last <= 1'b0;
                        // Word 0 (trigger PC) leaves idx at 0 so r0 is read next.
                        else if (word_is_reg) idx <= idx + 5'd1;
                    end
                end
                LOAD: begin
                    out_data    <= (idx == 5'd0) ? 32'd0 : reg_data;
                    out_last    <= (idx == 5'd31);
                    out_valid   <= 1'b1;
                    word_is_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sccomp_dump.sv
// Randomized scoreboard bench for sccomp_dump: a driver models the CPU PC and
// register file and queues the expected 33-word stream; a monitor checks handshakes.
module tb_sccomp_dump;

    localparam logic [31:0] HALT = 32'h00000048;
    localparam int          MAXC = 1000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        cpu_hold;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        done;
    logic        timeout;

    logic [31:0] rf [32];
    logic [31:0] exp_q [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          words_acc = 0;

    assign reg_data = rf[reg_sel];

    always #5 clk = ~clk;

    sccomp_dump #(.HALT_PC(HALT), .MAX_CYCLES(MAXC), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .pc(pc), .cpu_hold(cpu_hold), .reg_sel(reg_sel),
        .reg_data(reg_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .done(done), .timeout(timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: checks every accepted word against the queue and stall stability.
    initial begin
        logic        stalled;
        logic [31:0] pd;
        logic [4:0]  ps;
        logic        pl;
        logic [31:0] e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", out_data, pd);
                    check("stall_sel", 32'(reg_sel), 32'(ps));
                    check("stall_last", 32'(out_last), 32'(pl));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL extra_word: got %h expected no word", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", out_data, e);
                        check("last", 32'(out_last), 32'(exp_q.size() == 0));
                    end
                    words_acc++;
                end
                stalled = out_valid && !out_ready;
                pd = out_data;
                ps = reg_sel;
                pl = out_last;
            end
        end
    end

    // mode 0: PC ramp by 4; mode 1: random PC never HALT; mode 2: HALT only in cycle MAXC-1.
    function automatic logic [31:0] pc_for(input int mode, input int k);
        logic [31:0] v;
        if (mode == 0) return 32'(k * 4);
        if (mode == 2 && k == MAXC - 1) return HALT;
        v = $urandom() & 32'hFFFF_FFFC;
        if (v == HALT) v = HALT + 32'd4;
        return v;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_sel", 32'(reg_sel), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        exp_q.delete();
        words_acc = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run(input int mode, input int rmode, input int rst_at);
        int k;
        int t;
        int stall;
        bit tp;
        bit tt;
        bit exp_to;
        for (int i = 0; i < 32; i++) rf[i] = (mode == 0) ? 32'h100 + 32'(i) : $urandom();
        rf[0] = 32'hDEADBEEF;
        do_reset();
        k = 0;
        pc = pc_for(mode, 0);
        rstn = 1'b1;
        forever begin
            @(negedge clk);
            tp = (pc == HALT);
            tt = (k == MAXC - 1);
            if (tp || tt || k < 25) check("hold_run", 32'(cpu_hold), 32'(tp || tt));
            if (tp || tt) break;
            @(posedge clk);
            #1;
            k++;
            pc = pc_for(mode, k);
        end
        exp_q.push_back(pc);
        for (int i = 0; i < 32; i++) exp_q.push_back((i == 0) ? 32'd0 : rf[i]);
        exp_to = tt && !tp;
        t = 0;
        stall = 0;
        forever begin
            @(posedge clk);
            #1;
            t++;
            if (rst_at >= 0 && words_acc > rst_at) begin
                do_reset();
                return;
            end
            case (rmode)
                0: out_ready = 1'b1;
                1: begin
                    if (words_acc < 5) out_ready = 1'b1;
                    else if (words_acc == 5 && stall < 10) begin
                        out_ready = 1'b0;
                        stall++;
                    end else out_ready = ~out_ready;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (done) break;
            if (t > 600) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_wait: got no done after %0d cycles expected done", t);
                break;
            end
        end
        if (rmode == 0) check("done_latency", 32'(t), 32'd66);
        check("done", 32'(done), 32'd1);
        check("timeout", 32'(timeout), 32'(exp_to));
        check("hold_done", 32'(cpu_hold), 32'd1);
        check("valid_done", 32'(out_valid), 32'd0);
        check("word_count", 32'(words_acc), 32'd33);
        check("queue_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        run(0, 0, -1);
        run(0, 1, -1);
        run(1, 2, -1);
        run(2, 0, -1);
        run(0, 0, 10);
        run(1, 0, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
